// File: rtl/tile_pkg.sv
// Constants shared by the tile renderer blocks: tile geometry, ROM layout, map size and
// the scanner FSM state codes.
package tile_pkg;

    localparam int TILE_PX     = 8;
    localparam int TILE_BYTES  = 192;
    localparam int TILE_ROM_AW = 12;
    localparam int NUM_TILES   = 21;
    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;
    localparam int MAP_COLS    = SCREEN_W / TILE_PX;
    localparam int MAP_ROWS    = SCREEN_H / TILE_PX;
    localparam int MAP_AW      = 9;
    localparam int COL_W       = $clog2(MAP_COLS);
    localparam int ROW_W       = $clog2(MAP_ROWS);
    localparam int STATE_W     = 3;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT_RD   = 3'd2;
    localparam logic [STATE_W-1:0] S_DECODE    = 3'd3;
    localparam logic [STATE_W-1:0] S_ISSUE     = 3'd4;
    localparam logic [STATE_W-1:0] S_WAIT_DONE = 3'd5;
    localparam logic [STATE_W-1:0] S_ADVANCE   = 3'd6;
    localparam logic [STATE_W-1:0] S_DONE      = 3'd7;

    // idx*192 as two shifts; indices below NUM_TILES never overflow the 12-bit ROM space.
    function automatic logic [TILE_ROM_AW-1:0] tile_base(input logic [7:0] idx);
        logic [TILE_ROM_AW-1:0] w_idx;
        w_idx = TILE_ROM_AW'(idx);
        return (w_idx << 7) + (w_idx << 6);
    endfunction

endpackage

// File: rtl/tilemap_scanner_map_cursor.sv
// Row/column cursor over the tile map plus a linear map RAM address kept in step by
// incrementing, so no row*COLS multiply is needed.
module map_cursor
    import tile_pkg::*;
#(
    parameter int COLS  = MAP_COLS,
    parameter int ROWS  = MAP_ROWS,
    parameter int AW    = MAP_AW,
    parameter int CW    = COL_W,
    parameter int RW    = ROW_W
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_addr;
    logic          w_col_wrap;
    logic          w_last;

    assign w_col_wrap = (r_col == COL_LAST);
    assign w_last     = w_col_wrap && (r_row == ROW_LAST);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            r_addr <= r_addr + AW'(1);
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_addr = r_addr;
    assign o_last = w_last;

endmodule

// File: rtl/tilemap_scanner.sv
// Walks the tile map in row-major order and hands tiledrawer one job per valid cell,
// waiting for each job to finish before fetching the next cell.
//
//  state       | meaning
//  S_IDLE      | waiting for start
//  S_FETCH     | map_addr presented to map RAM
//  S_WAIT_RD   | map RAM read latency
//  S_DECODE    | check index, latch job; stall while drawer busy
//  S_ISSUE     | draw high until drawer reports active
//  S_WAIT_DONE | draw low until drawer goes idle
//  S_ADVANCE   | step cursor, finish after last cell
//  S_DONE      | one-cycle done pulse
module tilemap_scanner
    import tile_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_resetn,
    input  logic                   i_start,
    output logic [MAP_AW-1:0]      o_map_addr,
    input  logic [7:0]             i_map_data,
    output logic [TILE_ROM_AW-1:0] o_tile_address,
    output logic [7:0]             o_x_pos,
    output logic [7:0]             o_y_pos,
    output logic                   o_draw,
    input  logic                   i_drawer_active,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_bad_tile
);

    localparam logic [7:0] IDX_LIMIT = 8'(NUM_TILES);

    logic [STATE_W-1:0]     r_state;
    logic [TILE_ROM_AW-1:0] r_tile_address;
    logic [7:0]             r_x_pos;
    logic [7:0]             r_y_pos;
    logic                   r_bad_tile;

    logic                   w_clear;
    logic                   w_advance;
    logic                   w_last;
    logic                   w_idx_bad;
    logic [COL_W-1:0]       w_col;
    logic [ROW_W-1:0]       w_row;
    logic [MAP_AW-1:0]      w_map_addr;

    assign w_clear   = (r_state == S_IDLE) && i_start;
    assign w_advance = (r_state == S_ADVANCE);
    assign w_idx_bad = (i_map_data >= IDX_LIMIT);

    map_cursor u_cursor (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_addr    (w_map_addr),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state        <= S_IDLE;
            r_tile_address <= '0;
            r_x_pos        <= '0;
            r_y_pos        <= '0;
            r_bad_tile     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_FETCH;
                        r_bad_tile <= 1'b0;
                    end
                end
                S_FETCH:   r_state <= S_WAIT_RD;
                S_WAIT_RD: r_state <= S_DECODE;
                S_DECODE: begin
                    // Invalid cells are skipped at once; valid ones wait out a foreign drawer job.
                    if (w_idx_bad) begin
                        r_bad_tile <= 1'b1;
                        r_state    <= S_ADVANCE;
                    end else if (!i_drawer_active) begin
                        r_tile_address <= tile_base(i_map_data);
                        r_x_pos        <= 8'({w_col, 3'b000});
                        r_y_pos        <= 8'({w_row, 3'b000});
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_drawer_active) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!i_drawer_active) r_state <= S_ADVANCE;
                end
                S_ADVANCE: r_state <= w_last ? S_DONE : S_FETCH;
                S_DONE:    r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign o_map_addr     = w_map_addr;
    assign o_tile_address = r_tile_address;
    assign o_x_pos        = r_x_pos;
    assign o_y_pos        = r_y_pos;
    assign o_draw         = (r_state == S_ISSUE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_bad_tile     = r_bad_tile;

endmodule
